// File: rtl/jhash_lookup.sv
// Hash-dictionary lookup stage: indexes a tagged position table with each finished
// Jenkins hash, reports hit/miss plus the previous position, then overwrites the entry.
module jhash_lookup #(
  parameter int IDX_W = 10,
  parameter int POS_W = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_hash_out,
  input  logic             i_hash_done,
  input  logic [POS_W-1:0] i_pos,
  input  logic             i_clr,
  output logic             o_lk_ready,
  output logic             o_lk_ovf,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic             o_m_hit,
  output logic [POS_W-1:0] o_m_pos,
  output logic [IDX_W-1:0] o_m_idx
);

  localparam int TAG_W = 32 - IDX_W;
  localparam int ENT_W = 1 + TAG_W + POS_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_CLR  = 3'd0,
    S_IDLE = 3'd1,
    S_READ = 3'd2,
    S_CMP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_cnt;
  logic               r_clr_pend;
  logic               r_lk_ovf;
  logic               r_lk_ready;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_tag;
  logic [POS_W-1:0]   r_pos;
  logic               r_m_valid;
  logic               r_m_hit;
  logic [POS_W-1:0]   r_m_pos;
  logic [IDX_W-1:0]   r_m_idx;
  logic [ENT_W-1:0]   r_mem [0:DEPTH-1];
  logic [ENT_W-1:0]   r_rd;

  logic               w_take_clr;
  logic               w_take_hash;
  logic               w_clr_last;
  logic               w_rd_vld;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [POS_W-1:0]   w_rd_pos;
  logic               w_hit;
  logic               w_we;
  logic [IDX_W-1:0]   w_waddr;
  logic [ENT_W-1:0]   w_wdata;

  // A clear (live or pending) wins over a same-cycle hash strobe in IDLE.
  assign w_take_clr  = (r_state == S_IDLE) && (i_clr || r_clr_pend);
  assign w_take_hash = (r_state == S_IDLE) && !w_take_clr && i_hash_done;
  assign w_clr_last  = (r_cnt == {IDX_W{1'b1}});

  assign w_rd_vld = r_rd[ENT_W-1];
  assign w_rd_tag = r_rd[ENT_W-2 -: TAG_W];
  assign w_rd_pos = r_rd[POS_W-1:0];
  assign w_hit    = w_rd_vld && (w_rd_tag == r_tag);

  assign w_we    = (r_state == S_CLR) || (r_state == S_CMP);
  assign w_waddr = (r_state == S_CLR) ? r_cnt : r_idx;
  assign w_wdata = (r_state == S_CLR) ? {ENT_W{1'b0}} : {1'b1, r_tag, r_pos};

  // Table RAM: single port, writes in CLR/CMP, reads only on an accepted hash.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end else if (w_take_hash) begin
      r_rd <= r_mem[i_hash_out[IDX_W-1:0]];
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_CLR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLR: begin
        if (w_clr_last) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_CLR;
      end
      S_IDLE: begin
        if (w_take_clr)       w_state_nxt = S_CLR;
        else if (w_take_hash) w_state_nxt = S_READ;
        else                  w_state_nxt = S_IDLE;
      end
      S_READ:  w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = S_OUT;
      S_OUT: begin
        if (i_m_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_OUT;
      end
      default: w_state_nxt = S_CLR;
    endcase
  end

  // Datapath, status flags and registered result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= {IDX_W{1'b0}};
      r_clr_pend <= 1'b0;
      r_lk_ovf   <= 1'b0;
      r_lk_ready <= 1'b0;
      r_idx      <= {IDX_W{1'b0}};
      r_tag      <= {TAG_W{1'b0}};
      r_pos      <= {POS_W{1'b0}};
      r_m_valid  <= 1'b0;
      r_m_hit    <= 1'b0;
      r_m_pos    <= {POS_W{1'b0}};
      r_m_idx    <= {IDX_W{1'b0}};
    end else begin
      r_lk_ready <= (w_state_nxt == S_IDLE);

      if (r_state == S_CLR) begin
        r_cnt <= r_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
      end else if (w_take_clr) begin
        r_cnt <= {IDX_W{1'b0}};
      end

      if (w_take_clr) begin
        r_clr_pend <= 1'b0;
      end else if (i_clr && (r_state != S_IDLE)) begin
        r_clr_pend <= 1'b1;
      end

      // A hash dropped in favour of a clear still counts as an overflow.
      if (w_take_clr) begin
        r_lk_ovf <= i_hash_done;
      end else if (i_hash_done && (r_state != S_IDLE)) begin
        r_lk_ovf <= 1'b1;
      end

      if (w_take_hash) begin
        r_idx <= i_hash_out[IDX_W-1:0];
        r_tag <= i_hash_out[31:IDX_W];
        r_pos <= i_pos;
      end

      if (r_state == S_CMP) begin
        r_m_valid <= 1'b1;
        r_m_hit   <= w_hit;
        r_m_pos   <= w_hit ? w_rd_pos : {POS_W{1'b0}};
        r_m_idx   <= r_idx;
      end else if ((r_state == S_OUT) && i_m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign o_lk_ready = r_lk_ready;
  assign o_lk_ovf   = r_lk_ovf;
  assign o_m_valid  = r_m_valid;
  assign o_m_hit    = r_m_hit;
  assign o_m_pos    = r_m_pos;
  assign o_m_idx    = r_m_idx;

endmodule
